// File: rtl/jelly_histogram_accumulator.sv
// jelly_histogram_accumulator
// Purpose : builds a histogram of bin indices in an external single-port RAM.
//           It runs a clear pass, then accumulates samples, then reads the bins out.
// Latency : one sample is accepted per cycle with zero bubbles. Each bin is read
//           back in the same cycle that its address is presented.
// Backpressure: s_ready is high for the whole ACCUM phase. The readout stalls
//           on m_ready=0 and holds m_addr/m_count/m_last stable.
//
// Ports
//   clk, reset        : single clock, synchronous active-high reset
//   start             : pulse in IDLE that begins a clear pass (ignored elsewhere)
//   flush             : pulse in ACCUM that ends accumulation and starts readout
//   busy              : high whenever the controller is not IDLE
//   s_bin/s_valid/s_ready        : sample input stream
//   m_addr/m_count/m_last/m_valid/m_ready : bin readout stream, m_last on the final bin
//   ram_we/ram_addr/ram_din/ram_dout      : external RAM port (async read, sync write)

module jelly_histogram_accumulator #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16,
  parameter int SATURATE   = 1
) (
  input  logic                  reset,
  input  logic                  clk,
  input  logic                  start,
  input  logic                  flush,
  output logic                  busy,
  input  logic [ADDR_WIDTH-1:0] s_bin,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [DATA_WIDTH-1:0] m_count,
  output logic                  m_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_ACCUM = 2'd2,
    ST_READ  = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] CNT_LAST = '1;
  localparam logic [DATA_WIDTH-1:0] CNT_ONE  = DATA_WIDTH'(1);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;

  // Per-state flags are registered together with the state so that the
  // phase outputs come straight from flops.
  logic                    busy_q;
  logic                    clear_q;
  logic                    accum_q;
  logic                    read_q;

  logic                    cnt_is_last;
  logic                    sample_fire;
  logic [DATA_WIDTH-1:0]   bin_inc;

  assign cnt_is_last = (cnt_q == CNT_LAST);
  assign sample_fire = accum_q & s_valid;

  // Increment for the read-modify-write. An all-ones count either sticks
  // or rolls over to zero, depending on SATURATE.
  always_comb begin
    bin_inc = ram_dout + CNT_ONE;
    if (&ram_dout) begin
      bin_inc = (SATURATE != 0) ? {DATA_WIDTH{1'b1}} : {DATA_WIDTH{1'b0}};
    end
  end

  // Next-state and counter logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt_d   = '0;
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        // The counter wraps to zero after the last bin.
        cnt_d = cnt_q + 1'b1;
        if (cnt_is_last) begin
          state_d = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        // A sample that arrives with flush is still written this cycle.
        if (flush) begin
          cnt_d   = '0;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        if (m_ready) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_is_last) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      clear_q <= 1'b0;
      accum_q <= 1'b0;
      read_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d != ST_IDLE);
      clear_q <= (state_d == ST_CLEAR);
      accum_q <= (state_d == ST_ACCUM);
      read_q  <= (state_d == ST_READ);
    end
  end

  // The control outputs are masked by reset. This keeps them quiet while
  // reset is held, even before the first clock edge has been seen.
  assign busy    = busy_q  & ~reset;
  assign s_ready = accum_q & ~reset;
  assign m_valid = read_q  & ~reset;
  assign m_last  = m_valid & cnt_is_last;

  // The readout address is the counter, so it holds still while stalled.
  // The RAM is not written in READ, so m_count also holds still.
  assign m_addr  = cnt_q;
  assign m_count = ram_dout;

  // RAM port: clear writes zero at cnt. Accumulate does a read-modify-write
  // at s_bin. Every other state just presents cnt.
  assign ram_we   = ~reset & (clear_q | sample_fire);
  assign ram_addr = accum_q ? s_bin : cnt_q;
  assign ram_din  = accum_q ? bin_inc : {DATA_WIDTH{1'b0}};

endmodule

// File: tb/tb_jelly_histogram_accumulator.sv
// tb_jelly_histogram_accumulator
// Purpose : drives three copies of the accumulator from the same stimulus.
//           The copies use 16-bit counts with saturation, 4-bit counts with
//           saturation, and 4-bit counts with wrap-around.
// Each copy has its own async-read RAM. All readouts are compared against
// one array of true (unbounded) bin counts.

module tb_jelly_histogram_accumulator;

  localparam int AW = 6;
  localparam int N  = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          flush;
  logic          s_valid;
  logic          m_ready;
  logic [AW-1:0] s_bin;
  logic          fill;

  always #5 clk = ~clk;

  // copy A: 16-bit, saturating
  logic          a_busy, a_s_ready, a_m_last, a_m_valid, a_ram_we;
  logic [AW-1:0] a_m_addr, a_ram_addr;
  logic [15:0]   a_m_count, a_ram_din, a_ram_dout;
  logic [15:0]   a_mem [N];

  // copy B: 4-bit, saturating
  logic          b_busy, b_s_ready, b_m_last, b_m_valid, b_ram_we;
  logic [AW-1:0] b_m_addr, b_ram_addr;
  logic [3:0]    b_m_count, b_ram_din, b_ram_dout;
  logic [3:0]    b_mem [N];

  // copy C: 4-bit, wrapping
  logic          c_busy, c_s_ready, c_m_last, c_m_valid, c_ram_we;
  logic [AW-1:0] c_m_addr, c_ram_addr;
  logic [3:0]    c_m_count, c_ram_din, c_ram_dout;
  logic [3:0]    c_mem [N];

  assign a_ram_dout = a_mem[a_ram_addr];
  assign b_ram_dout = b_mem[b_ram_addr];
  assign c_ram_dout = c_mem[c_ram_addr];

  // While fill is high, the RAMs are loaded with garbage so that the clear
  // pass has real work to do.
  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < N; i++) a_mem[i] <= 16'($urandom);
    end else if (a_ram_we) begin
      a_mem[a_ram_addr] <= a_ram_din;
    end
  end

  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < N; i++) b_mem[i] <= 4'($urandom);
    end else if (b_ram_we) begin
      b_mem[b_ram_addr] <= b_ram_din;
    end
  end

  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < N; i++) c_mem[i] <= 4'($urandom);
    end else if (c_ram_we) begin
      c_mem[c_ram_addr] <= c_ram_din;
    end
  end

  jelly_histogram_accumulator #(.ADDR_WIDTH(AW), .DATA_WIDTH(16), .SATURATE(1)) dut_a (
    .reset(reset), .clk(clk), .start(start), .flush(flush), .busy(a_busy),
    .s_bin(s_bin), .s_valid(s_valid), .s_ready(a_s_ready),
    .m_addr(a_m_addr), .m_count(a_m_count), .m_last(a_m_last),
    .m_valid(a_m_valid), .m_ready(m_ready),
    .ram_we(a_ram_we), .ram_addr(a_ram_addr), .ram_din(a_ram_din), .ram_dout(a_ram_dout)
  );

  jelly_histogram_accumulator #(.ADDR_WIDTH(AW), .DATA_WIDTH(4), .SATURATE(1)) dut_b (
    .reset(reset), .clk(clk), .start(start), .flush(flush), .busy(b_busy),
    .s_bin(s_bin), .s_valid(s_valid), .s_ready(b_s_ready),
    .m_addr(b_m_addr), .m_count(b_m_count), .m_last(b_m_last),
    .m_valid(b_m_valid), .m_ready(m_ready),
    .ram_we(b_ram_we), .ram_addr(b_ram_addr), .ram_din(b_ram_din), .ram_dout(b_ram_dout)
  );

  jelly_histogram_accumulator #(.ADDR_WIDTH(AW), .DATA_WIDTH(4), .SATURATE(0)) dut_c (
    .reset(reset), .clk(clk), .start(start), .flush(flush), .busy(c_busy),
    .s_bin(s_bin), .s_valid(s_valid), .s_ready(c_s_ready),
    .m_addr(c_m_addr), .m_count(c_m_count), .m_last(c_m_last),
    .m_valid(c_m_valid), .m_ready(m_ready),
    .ram_we(c_ram_we), .ram_addr(c_ram_addr), .ram_din(c_ram_din), .ram_dout(c_ram_dout)
  );

  // Reference: true number of samples seen per bin since the last start
  int hist [N];
  int checks = 0;
  int errors = 0;

  function automatic int clamp16(input int c);
    return (c > 65535) ? 65535 : c;
  endfunction

  function automatic int clamp4(input int c);
    return (c > 15) ? 15 : c;
  endfunction

  function automatic int wrap4(input int c);
    return c % 16;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    start   = 1'b0;
    flush   = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    s_bin   = '0;
  endtask

  // Pulses start from IDLE, then checks every cycle of the clear pass.
  // Random start/flush/s_valid values are driven meanwhile and must be ignored.
  task automatic do_clear();
    start = 1'b1;
    mid();
    chk("idle_before_start_busy", a_busy, 1'b0);
    next_cycle();
    for (int k = 0; k < N; k++) begin
      start   = 1'($urandom);
      flush   = 1'($urandom);
      s_valid = 1'($urandom);
      s_bin   = AW'($urandom);
      mid();
      chk("clear_busy", a_busy, 1'b1);
      chk("clear_we", a_ram_we, 1'b1);
      chk("clear_addr", a_ram_addr, k);
      chk("clear_din", a_ram_din, 0);
      chk("clear_s_ready", a_s_ready, 1'b0);
      chk("clear_m_valid", a_m_valid, 1'b0);
      chk("clear_din_b", b_ram_din, 0);
      chk("clear_din_c", c_ram_din, 0);
      next_cycle();
    end
    idle_inputs();
    for (int i = 0; i < N; i++) hist[i] = 0;
  endtask

  // One ACCUM cycle. A random start is also driven and must be ignored.
  task automatic accum_cycle(input logic v, input logic [AW-1:0] b, input logic f);
    s_valid = v;
    s_bin   = b;
    flush   = f;
    start   = 1'($urandom);
    m_ready = 1'($urandom);
    mid();
    chk("accum_s_ready", a_s_ready, 1'b1);
    chk("accum_busy", a_busy, 1'b1);
    chk("accum_m_valid", a_m_valid, 1'b0);
    chk("accum_addr", a_ram_addr, b);
    chk("accum_we", a_ram_we, v);
    if (v) begin
      chk("accum_din_a", a_ram_din, clamp16(hist[b] + 1));
      chk("accum_din_b", b_ram_din, clamp4(hist[b] + 1));
      chk("accum_din_c", c_ram_din, wrap4(hist[b] + 1));
    end
    next_cycle();
    if (v) hist[b]++;
    idle_inputs();
  endtask

  // Readout with random m_ready. The expected values depend only on the
  // transfer index, so any drift while stalled is caught.
  task automatic readout();
    int idx = 0;
    int cyc = 0;
    while (idx < N && cyc < 4000) begin
      m_ready = ($urandom_range(0, 3) != 0);
      start   = 1'($urandom);
      flush   = 1'($urandom);
      s_valid = 1'($urandom);
      s_bin   = AW'($urandom);
      mid();
      chk("read_m_valid", a_m_valid, 1'b1);
      chk("read_busy", a_busy, 1'b1);
      chk("read_we", a_ram_we, 1'b0);
      chk("read_s_ready", a_s_ready, 1'b0);
      chk("read_m_addr", a_m_addr, idx);
      chk("read_m_last", a_m_last, (idx == N - 1));
      chk("read_count_a", a_m_count, clamp16(hist[idx]));
      chk("read_count_b", b_m_count, clamp4(hist[idx]));
      chk("read_count_c", c_m_count, wrap4(hist[idx]));
      chk("read_m_valid_bc", {b_m_valid, c_m_valid}, 2'b11);
      next_cycle();
      if (m_ready) idx++;
      cyc++;
    end
    if (idx < N) chk("read_timeout_transfers", idx, N);
    idle_inputs();
    mid();
    chk("post_read_busy", a_busy, 1'b0);
    chk("post_read_m_valid", a_m_valid, 1'b0);
    chk("post_read_we", a_ram_we, 1'b0);
    next_cycle();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog_timeout observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    reset = 1'b1;
    fill  = 1'b1;

    // reset state
    mid();
    chk("rst_busy", a_busy, 1'b0);
    chk("rst_s_ready", a_s_ready, 1'b0);
    chk("rst_m_valid", a_m_valid, 1'b0);
    chk("rst_m_last", a_m_last, 1'b0);
    chk("rst_we", a_ram_we, 1'b0);
    next_cycle();
    fill = 1'b0;
    next_cycle();
    reset = 1'b0;
    mid();
    chk("post_rst_busy", a_busy, 1'b0);
    chk("post_rst_we", a_ram_we, 1'b0);
    chk("post_rst_m_valid", a_m_valid, 1'b0);
    chk("post_rst_addr", a_ram_addr, 0);
    next_cycle();

    // flush has no effect in IDLE
    flush = 1'b1;
    next_cycle();
    flush = 1'b0;
    mid();
    chk("idle_flush_ignored", a_busy, 1'b0);
    next_cycle();

    // directed: bins 5,5,5,9 back-to-back, then flush alone
    do_clear();
    accum_cycle(1'b1, 6'd5, 1'b0);
    accum_cycle(1'b1, 6'd5, 1'b0);
    accum_cycle(1'b1, 6'd5, 1'b0);
    accum_cycle(1'b1, 6'd9, 1'b0);
    accum_cycle(1'b0, 6'd0, 1'b1);
    readout();

    // 17 samples to bin 2 exercise saturate vs. wrap, then flush with a sample on bin 7
    do_clear();
    for (int i = 0; i < 17; i++) accum_cycle(1'b1, 6'd2, 1'b0);
    accum_cycle(1'b0, 6'd2, 1'b0);
    accum_cycle(1'b1, 6'd7, 1'b0);
    accum_cycle(1'b1, 6'd7, 1'b1);
    readout();

    // random sample stream concentrated on a few bins
    do_clear();
    for (int i = 0; i < 400; i++) begin
      accum_cycle(($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 2) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7)),
                  1'b0);
    end
    accum_cycle(1'($urandom), AW'($urandom), 1'b1);
    readout();

    // reset in the middle of a clear pass, at cnt=20
    start = 1'b1;
    next_cycle();
    start = 1'b0;
    for (int k = 0; k < 20; k++) next_cycle();
    mid();
    chk("midclear_addr", a_ram_addr, 20);
    chk("midclear_we", a_ram_we, 1'b1);
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    mid();
    chk("midclear_rst_busy", a_busy, 1'b0);
    chk("midclear_rst_we", a_ram_we, 1'b0);
    chk("midclear_rst_addr", a_ram_addr, 0);
    next_cycle();
    do_clear();
    accum_cycle(1'b1, 6'd63, 1'b0);
    accum_cycle(1'b1, 6'd0, 1'b1);
    readout();

    // reset in the middle of a readout
    do_clear();
    accum_cycle(1'b1, 6'd3, 1'b1);
    m_ready = 1'b1;
    next_cycle();
    mid();
    chk("midread_addr", a_m_addr, 1);
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    idle_inputs();
    mid();
    chk("midread_rst_busy", a_busy, 1'b0);
    chk("midread_rst_m_valid", a_m_valid, 1'b0);
    chk("midread_rst_m_last", a_m_last, 1'b0);
    next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
